// File: rtl/ov7670_config_seq.sv
// rtl/ov7670_config_seq.sv - OV7670 register-config ROM walker issuing one SCCB write per entry
// Handles 0xFFF0 delay and 0xFFFF end markers and retries NACKed writes before flagging error.
module ov7670_config_seq #(
   parameter int unsigned DELAY_CYCLES = 1_000_000,
   parameter int unsigned GAP_CYCLES   = 100,
   parameter int unsigned MAX_RETRY    = 3
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   output logic [7:0]  o_rom_addr,
   input  logic [15:0] i_rom_data,
   output logic        o_sccb_start,
   output logic [7:0]  o_sccb_reg,
   output logic [7:0]  o_sccb_val,
   input  logic        i_sccb_busy,
   input  logic        i_sccb_done,
   input  logic        i_sccb_nack,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [7:0]  o_wr_count
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_GAP, S_DELAY, S_DONE, S_ERROR
   } state_t;

   // Counters are loaded with N-1 so the counting state lasts exactly N cycles.
   localparam logic [31:0] C_DELAY_LOAD = (DELAY_CYCLES == 0) ? 32'd0 : 32'(DELAY_CYCLES - 1);
   localparam logic [31:0] C_GAP_LOAD   = (GAP_CYCLES == 0)   ? 32'd0 : 32'(GAP_CYCLES - 1);
   localparam logic [7:0]  C_MAX_RETRY  = 8'(MAX_RETRY);

   state_t      r_state;
   logic [31:0] r_cnt;
   logic [7:0]  r_retry;
   logic        r_retry_pend;
   logic [7:0]  r_rom_addr;
   logic        r_sccb_start;
   logic [7:0]  r_sccb_reg;
   logic [7:0]  r_sccb_val;
   logic        r_busy;
   logic        r_done;
   logic        r_error;
   logic [7:0]  r_wr_count;
   logic        w_last_addr;

   assign w_last_addr  = (r_rom_addr == 8'hFF);
   assign o_rom_addr   = r_rom_addr;
   assign o_sccb_start = r_sccb_start;
   assign o_sccb_reg   = r_sccb_reg;
   assign o_sccb_val   = r_sccb_val;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_error      = r_error;
   assign o_wr_count   = r_wr_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= 32'd0;
         r_retry      <= 8'd0;
         r_retry_pend <= 1'b0;
         r_rom_addr   <= 8'd0;
         r_sccb_start <= 1'b0;
         r_sccb_reg   <= 8'd0;
         r_sccb_val   <= 8'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_wr_count   <= 8'd0;
      end else begin
         r_sccb_start <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (i_start) begin
                  r_rom_addr   <= 8'd0;
                  r_wr_count   <= 8'd0;
                  r_done       <= 1'b0;
                  r_error      <= 1'b0;
                  r_busy       <= 1'b1;
                  r_retry      <= 8'd0;
                  r_retry_pend <= 1'b0;
                  r_state      <= S_FETCH;
               end
            end
            S_FETCH: r_state <= S_DECODE;
            S_DECODE: begin
               if (i_rom_data == 16'hFFFF) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end else if (i_rom_data == 16'hFFF0) begin
                  r_cnt   <= C_DELAY_LOAD;
                  r_state <= S_DELAY;
               end else begin
                  r_sccb_reg <= i_rom_data[15:8];
                  r_sccb_val <= i_rom_data[7:0];
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!i_sccb_busy) begin
                  r_sccb_start <= 1'b1;
                  r_state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_sccb_done) begin
                  r_cnt   <= C_GAP_LOAD;
                  r_state <= S_GAP;
                  if (!i_sccb_nack) begin
                     if (r_wr_count != 8'hFF) r_wr_count <= r_wr_count + 8'd1;
                     r_retry      <= 8'd0;
                     r_retry_pend <= 1'b0;
                  end else if (r_retry < C_MAX_RETRY) begin
                     r_retry      <= r_retry + 8'd1;
                     r_retry_pend <= 1'b1;
                  end else begin
                     r_error <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_ERROR;
                  end
               end
            end
            S_GAP, S_DELAY: begin
               if (r_cnt != 32'd0) begin
                  r_cnt <= r_cnt - 32'd1;
               end else if (r_state == S_GAP && r_retry_pend) begin
                  r_retry_pend <= 1'b0;
                  r_state      <= S_ISSUE;
               end else if (w_last_addr) begin
                  // A ROM without an end marker stops at the top instead of wrapping.
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_rom_addr <= r_rom_addr + 8'd1;
                  r_state    <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
